// File: rtl/instr_encoder_loader.sv
// Packs decoded ARM-subset instruction descriptors into 32-bit machine words
// and writes them to consecutive instruction-memory words, one session per start.
module instr_encoder_loader #(
    parameter int AW    = 32,
    parameter int DEPTH = 64,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [2:0]    in_kind,
    input  logic [3:0]    in_cond,
    input  logic [3:0]    in_cmd,
    input  logic          in_s,
    input  logic [3:0]    in_rn,
    input  logic [3:0]    in_rd,
    input  logic [3:0]    in_rm,
    input  logic          in_sh,
    input  logic [4:0]    in_shamt,
    input  logic [11:0]   in_imm,
    input  logic [AW-1:0] in_target,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] count
);

    localparam logic [2:0] K_DP_IMM = 3'd0;
    localparam logic [2:0] K_DP_REG = 3'd1;
    localparam logic [2:0] K_LDR    = 3'd2;
    localparam logic [2:0] K_STR    = 3'd3;
    localparam logic [2:0] K_B      = 3'd4;
    localparam logic [2:0] K_SHIFT  = 3'd5;
    localparam logic [3:0] CMD_CMP  = 4'b1010;
    localparam logic [3:0] CMD_MOV  = 4'b1101;

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_e;

    state_e        state, state_next;
    logic [AW-1:0] addr_q;
    logic [31:0]   word_q;
    logic          last_q;
    logic [CW-1:0] count_q;
    logic          err_q;

    logic [31:0]   enc_word;
    logic          enc_illegal;
    logic          dp_s;
    logic [3:0]    dp_rd;
    logic [AW-1:0] br_diff;
    logic          accept;

    assign accept = (state == S_ACCEPT) && in_valid;

    // The branch offset is relative to the address this word will occupy (addr_q),
    // plus the 8-byte pipeline offset; bits [25:2] give the truncated arithmetic >>> 2.
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        enc_word    = '0;
        enc_illegal = 1'b0;
        br_diff     = in_target - (addr_q + AW'(8));
        dp_s        = (in_cmd == CMD_CMP) ? 1'b1 : in_s;
        dp_rd       = (in_cmd == CMD_CMP) ? 4'h0 : in_rd;
        case (in_kind)
            K_DP_IMM: begin
                enc_word    = {in_cond, 2'b00, 1'b1, in_cmd, dp_s, in_rn, dp_rd,
                               4'h0, in_imm[7:0]};
                enc_illegal = |in_imm[11:8];
            end
            K_DP_REG: enc_word = {in_cond, 2'b00, 1'b0, in_cmd, dp_s, in_rn, dp_rd,
                                  5'd0, 2'b00, 1'b0, in_rm};
            K_LDR:    enc_word = {in_cond, 2'b01, 6'b011001, in_rn, in_rd, in_imm};
            K_STR:    enc_word = {in_cond, 2'b01, 6'b011000, in_rn, in_rd, in_imm};
            K_B: begin
                enc_word    = {in_cond, 4'b1010, br_diff[25:2]};
                enc_illegal = |in_target[1:0];
            end
            K_SHIFT:  enc_word = {in_cond, 2'b00, 1'b0, CMD_MOV, in_s, 4'h0, in_rd,
                                  in_shamt, 1'b0, in_sh, 1'b0, in_rm};
            default:  enc_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_ACCEPT;
            S_ACCEPT: if (in_valid) begin
                if (!enc_illegal)  state_next = S_WRITE;
                else if (in_last)  state_next = S_DONE;
            end
            S_WRITE:  state_next = (last_q || count_q == CW'(DEPTH - 1)) ? S_DONE : S_ACCEPT;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    addr_q  <= base_addr;
                    count_q <= '0;
                    err_q   <= 1'b0;
                end
                S_ACCEPT: if (accept) begin
                    if (enc_illegal) begin
                        err_q <= 1'b1;
                    end else begin
                        word_q <= enc_word;
                        last_q <= in_last;
                    end
                end
                S_WRITE: begin
                    addr_q  <= addr_q + AW'(4);
                    count_q <= count_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == S_ACCEPT);
    assign mem_we    = (state == S_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential instruction encoder for the single-cycle ARM-subset core. It accepts decoded instruction descriptors over a valid/ready stream, packs each into the 32-bit machine word that the core's decoder expects, and writes the words to consecutive word addresses of instruction memory. It sits between the test or boot controller and the instruction-memory write port. It covers the same subset the core executes: DP imm/reg, LDR/STR, B and LSL/LSR.

## Interface
- AW, 32, byte-address width
- DEPTH, 64, max words per load session
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  pulse; opens a session at base_addr (ignored unless IDLE)
- base_addr  in  AW  word-aligned start address
- in_valid  in  1  descriptor valid
- in_ready  out  1  encoder can accept a descriptor
- in_last  in  1  final descriptor of the session
- in_kind  in  3  0 DP-imm, 1 DP-reg, 2 LDR, 3 STR, 4 B, 5 SHIFT; 6-7 illegal
- in_cond  in  4  condition field
- in_cmd  in  4  DP cmd (ADD 0100, SUB 0010, AND 0000, ORR 1100, CMP 1010)
- in_s  in  1  S bit (DP only)
- in_rn, in_rd, in_rm  in  4 each  register numbers
- in_sh  in  1  SHIFT type: 0 LSL, 1 LSR
- in_shamt  in  5  shift amount
- in_imm  in  12  immediate / memory offset
- in_target  in  AW  branch target byte address
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  AW  write address
- mem_wdata  out  32  encoded word
- busy  out  1  session active
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky; illegal kind, DP imm >255, or misaligned branch target
- count  out  clog2(DEPTH+1)  words written this session

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: in_ready=0. start -> addr<=base_addr, count<=0, err<=0, go to ACCEPT.
- ACCEPT: in_ready=1. On in_valid&in_ready, latch the encoded word and in_last, then go to WRITE.
- An illegal descriptor sets err. No write occurs. Go to DONE if in_last, else stay in ACCEPT.
- WRITE: mem_we=1 with addr/word. Then addr<=addr+4 and count<=count+1. Go to DONE if in_last or count+1==DEPTH, else go to ACCEPT.
- DONE: done=1 for one cycle, then IDLE.
- Encodings. All words have cond in [31:28].
- DP-imm: [27:26]=00, I=1, cmd, S, Rn, Rd, rot=0, imm8=in_imm[7:0]. in_imm[11:8]!=0 -> err, no write.
- DP-reg: I=0, cmd, S, Rn, Rd, shamt=0, sh=00, bit4=0, Rm.
- CMP (cmd 1010): S is forced to 1 and Rd is forced to 0.
- LDR/STR: [27:26]=01. Bits [25:20]=0,1,1,0,0,L with L=1 for LDR. Then Rn, Rd, imm12=in_imm.
- B: [27:24]=1010. imm24 = (in_target - (addr+8)) >>> 2, truncated to 24 bits. in_target[1:0]!=0 -> err, no write.
- SHIFT: DP-reg with cmd 1101, S=in_s, Rn=0, Rd, shamt=in_shamt, sh={0,in_sh}, bit4=0, Rm.
- Arithmetic: address and offset math is modulo 2^AW. The branch subtraction is two's complement.
- busy=1 in ACCEPT/WRITE/DONE.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, count=0, state IDLE.
- Reset mid-session aborts immediately. No write is issued after reset asserts.
- Latency: a descriptor accepted at edge N produces mem_we high during cycle N+1. in_ready returns in cycle N+2.
- Throughput: one word per 2 cycles.
- mem_addr/mem_wdata are stable for the whole mem_we cycle.
- in_ready is driven from state only, with no combinational path from in_valid.
- When count reaches DEPTH, the session ends even without in_last. Later descriptors wait until the next start.
- start during busy is ignored. start and reset together: reset wins.
- in_valid in IDLE or DONE is not accepted.

## Test plan
- ADD R1,R2,#5, cond E, base 0 -> one write: addr 0x0, data 0xE2821005. Then done pulses and count=1.
- Stream, base 0x100: LDR R3,[R4,#8]; STR R3,[R4,#8]; CMP R1,R2 (in_s=0), last. Required writes:
  - 0x100 = 0xE5943008
  - 0x104 = 0xE5843008
  - 0x108 = 0xE1510002
  - count=3
- B at addr 0x10 to target 0x08 -> 0xEAFFFFFC. Target 0x0A -> err=1, no write.
- LSL R5,R6,#3, cond E -> 0xE1A05186. Kind 7 with in_last -> err=1, no write, done pulses.
- DEPTH=2 with 3 valid descriptors: the first two are written, done pulses after the second, and the third is held until the next start.
- Reset asserted during WRITE -> mem_we=0 and all outputs at reset values the same cycle. A new start then writes from base_addr.
